// File: rtl/decode_stage_rv.sv
// Decode stage: IF/ID register, RV32I/RV32E decoder, register file with WB bypass, sticky illegal flag, decode counter.
// Outputs are combinational one edge after fetch acceptance; StallD holds the slot, FlushD inserts a bubble.
module decode_stage_rv #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             ValidF,
  input  logic [31:0]      InstrF,
  input  logic [XLEN-1:0]  PCF,
  input  logic [XLEN-1:0]  PCPlus4F,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  ResultW,
  output logic             ValidD,
  output logic             RegWriteD,
  output logic             MemWriteD,
  output logic             JumpD,
  output logic             BranchD,
  output logic             ALUSrcD,
  output logic [1:0]       ResultSrcD,
  output logic [1:0]       SrcASelD,
  output logic [3:0]       ALUControlD,
  output logic [2:0]       Funct3D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic [XLEN-1:0]  ExtImmD,
  output logic [4:0]       Rs1D,
  output logic [4:0]       Rs2D,
  output logic [4:0]       RdD,
  output logic             IllegalD,
  output logic             IllegalSeen,
  output logic [CNT_W-1:0] DecodeCount
);
  localparam int AW = $clog2(NREG);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  logic [31:0]      instr_q, instr_d;
  logic [XLEN-1:0]  pc_q, pc_d, pcp4_q, pcp4_d;
  logic             valid_q, valid_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rf_q [NREG];

  // IF/ID register: flush beats stall
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP;
      pc_d    = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (!StallD) begin
      instr_d = InstrF;
      pc_d    = PCF;
      pcp4_d  = PCPlus4F;
      valid_d = ValidF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  logic rf_we;
  assign rf_we = RegWriteW && (RdW != 5'd0) && ({27'd0, RdW} < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[RdW[AW-1:0]] <= ResultW;
    end
  end

  logic [6:0] opc;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc   = instr_q[6:0];
  assign rd_f  = instr_q[11:7];
  assign f3    = instr_q[14:12];
  assign rs1_f = instr_q[19:15];
  assign rs2_f = instr_q[24:20];
  assign f7    = instr_q[31:25];

  logic       reg_write, mem_write, jump, branch, alu_src, bad_enc;
  logic       use_rs1, use_rs2, use_rd, alt;
  logic [1:0] result_src, srca_sel;
  logic [3:0] alu_ctrl, arith_ctrl;
  logic [31:0] imm;

  // OP/OP-IMM share the funct3 mapping; 'alt' selects SUB/SRA
  always_comb begin
    case (f3)
      3'd0:    arith_ctrl = alt ? ALU_SUB : ALU_ADD;
      3'd1:    arith_ctrl = ALU_SLL;
      3'd2:    arith_ctrl = ALU_SLT;
      3'd3:    arith_ctrl = ALU_SLTU;
      3'd4:    arith_ctrl = ALU_XOR;
      3'd5:    arith_ctrl = alt ? ALU_SRA : ALU_SRL;
      3'd6:    arith_ctrl = ALU_OR;
      default: arith_ctrl = ALU_AND;
    endcase
  end

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    srca_sel   = 2'b00;
    alu_ctrl   = ALU_ADD;
    imm        = '0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    alt        = 1'b0;
    bad_enc    = 1'b0;
    case (opc)
      OPC_OP: begin
        reg_write = 1'b1;
        {use_rs1, use_rs2, use_rd} = 3'b111;
        alt      = f7[5];
        alu_ctrl = arith_ctrl;
        bad_enc  = (f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
      end
      OPC_OPIMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        alt      = (f3 == 3'd5) && f7[5];
        alu_ctrl = arith_ctrl;
        imm      = {{20{instr_q[31]}}, instr_q[31:20]};
        bad_enc  = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        {use_rs1, use_rd} = 2'b11;
        imm     = {{20{instr_q[31]}}, instr_q[31:20]};
        bad_enc = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        {use_rs1, use_rs2} = 2'b11;
        imm     = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        bad_enc = (f3 > 3'd2);
      end
      OPC_BRANCH: begin
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
        {use_rs1, use_rs2} = 2'b11;
        imm     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
        bad_enc = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = 2'b10;
        use_rd     = 1'b1;
        imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      end
      OPC_JALR: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = 2'b10;
        alu_src    = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        imm     = {{20{instr_q[31]}}, instr_q[31:20]};
        bad_enc = (f3 != 3'd0);
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        srca_sel  = 2'b10;
        use_rd    = 1'b1;
        imm       = {instr_q[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        srca_sel  = 2'b01;
        use_rd    = 1'b1;
        imm       = {instr_q[31:12], 12'd0};
      end
      default: bad_enc = 1'b1;
    endcase
  end

  logic bad_reg;
  assign bad_reg = (use_rs1 && ({27'd0, rs1_f} >= NREG)) ||
                   (use_rs2 && ({27'd0, rs2_f} >= NREG)) ||
                   (use_rd  && ({27'd0, rd_f}  >= NREG));

  assign IllegalD = valid_q && (bad_enc || bad_reg);
  assign ValidD   = valid_q && !IllegalD;

  assign Rs1D = use_rs1 ? rs1_f : 5'd0;
  assign Rs2D = use_rs2 ? rs2_f : 5'd0;
  assign RdD  = use_rd  ? rd_f  : 5'd0;

  // Out-of-range indices read zero; a same-cycle WB write overrides the array when bypass is on
  always_comb begin
    RD1D = '0;
    RD2D = '0;
    if (Rs1D != 5'd0 && {27'd0, Rs1D} < NREG) RD1D = rf_q[Rs1D[AW-1:0]];
    if (Rs2D != 5'd0 && {27'd0, Rs2D} < NREG) RD2D = rf_q[Rs2D[AW-1:0]];
    if (BYPASS != 0 && rf_we && RdW == Rs1D) RD1D = ResultW;
    if (BYPASS != 0 && rf_we && RdW == Rs2D) RD2D = ResultW;
  end

  assign RegWriteD   = reg_write & ValidD;
  assign MemWriteD   = mem_write & ValidD;
  assign JumpD       = jump      & ValidD;
  assign BranchD     = branch    & ValidD;
  assign ALUSrcD     = alu_src   & ValidD;
  assign ResultSrcD  = result_src & {2{ValidD}};
  assign SrcASelD    = srca_sel   & {2{ValidD}};
  assign ALUControlD = alu_ctrl   & {4{ValidD}};
  assign Funct3D     = f3;
  assign ExtImmD     = imm[XLEN-1:0];
  assign PCD         = pc_q;
  assign PCPlus4D    = pcp4_q;

  assign seen_d = seen_q | IllegalD;
  assign cnt_d  = (ValidD && !StallD) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

  assign IllegalSeen = seen_q;
  assign DecodeCount = cnt_q;
endmodule
